// File: rtl/fourth_stage.sv
// Memory-access pipeline stage: sized data-memory loads/stores with
// misalignment detection, plus the MEM/WB pipeline register.
module fourth_stage #(
    parameter int Width = 32,
    parameter int Depth = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] ALUResult,
    input  logic [Width-1:0] WriteData,
    input  logic [4:0]       Rd,
    input  logic [2:0]       funct3,
    input  logic [4:0]       controlsignals,
    input  logic             stall,
    input  logic             flush,
    output logic [Width-1:0] readData,
    output logic [Width-1:0] ALUResult_wb,
    output logic [2:0]       controlsignals_wb,
    output logic [4:0]       Rd_wb,
    output logic             misalign
);
    localparam int AW = $clog2(Depth);

    logic [Width-1:0] r_mem [Depth];

    logic             w_valid, w_regwr, w_m2r, w_rd, w_wr;
    logic [AW-1:0]    w_idx;
    logic [1:0]       w_off;
    logic             w_byte, w_half, w_word, w_sgn;
    logic             w_mis, w_we;
    logic [3:0]       w_be;
    logic [Width-1:0] w_wdata, w_rword, w_ld;
    logic [7:0]       w_b;
    logic [15:0]      w_h;

    assign {w_valid, w_regwr, w_m2r, w_rd, w_wr} = controlsignals;
    assign w_idx = ALUResult[AW+1:2];
    assign w_off = ALUResult[1:0];

    always_comb begin
        w_byte = 1'b0;
        w_half = 1'b0;
        w_word = 1'b0;
        w_sgn  = 1'b0;
        case (funct3)
            3'b000: begin w_byte = 1'b1; w_sgn = 1'b1; end
            3'b001: begin w_half = 1'b1; w_sgn = 1'b1; end
            3'b010: w_word = 1'b1;
            3'b100: w_byte = 1'b1;
            3'b101: w_half = 1'b1;
            default: ;
        endcase
    end

    // Unsupported sizes are folded into the misaligned case.
    assign w_mis = w_valid & (w_rd | w_wr) &
                   ((~w_byte & ~w_half & ~w_word) |
                    (w_half & w_off[0]) |
                    (w_word & (w_off != 2'b00)));

    assign w_we = w_valid & w_wr & ~w_mis & ~stall;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = WriteData;
        unique case (1'b1)
            w_byte: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{WriteData[7:0]}};
            end
            w_half: begin
                w_be    = 4'b0011 << w_off;
                w_wdata = {2{WriteData[15:0]}};
            end
            w_word: w_be = 4'b1111;
            default: ;
        endcase
    end

    // Reset only gates the write; memory contents are never cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
        end else if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    assign w_rword = r_mem[w_idx];
    assign w_b     = 8'(w_rword >> {w_off, 3'b000});
    assign w_h     = 16'(w_rword >> {w_off[1], 4'b0000});

    always_comb begin
        w_ld = '0;
        if (w_valid & w_rd & ~w_wr & ~w_mis) begin
            unique case (1'b1)
                w_byte:  w_ld = {{24{w_sgn & w_b[7]}}, w_b};
                w_half:  w_ld = {{16{w_sgn & w_h[15]}}, w_h};
                w_word:  w_ld = w_rword;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            readData          <= '0;
            ALUResult_wb      <= '0;
            controlsignals_wb <= 3'b000;
            Rd_wb             <= 5'd0;
            misalign          <= 1'b0;
        end else if (flush) begin
            readData          <= '0;
            ALUResult_wb      <= '0;
            controlsignals_wb <= 3'b000;
            Rd_wb             <= 5'd0;
            misalign          <= 1'b0;
        end else if (!stall) begin
            readData          <= w_ld;
            ALUResult_wb      <= ALUResult;
            controlsignals_wb <= {w_valid, w_valid & w_regwr & ~w_mis, w_m2r};
            Rd_wb             <= Rd;
            misalign          <= w_mis;
        end
    end
endmodule

// File: tb/tb_fourth_stage.sv
// Self-checking bench for fourth_stage: directed plan cases plus
// randomized traffic against a byte-array reference model.
module tb_fourth_stage;
    localparam int W = 32;
    localparam int D = 64;
    localparam logic [4:0] LD = 5'b11110;
    localparam logic [4:0] ST = 5'b10001;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] ALUResult = '0, WriteData = '0;
    logic [4:0]   Rd = '0;
    logic [2:0]   funct3 = '0;
    logic [4:0]   controlsignals = '0;
    logic         stall = 1'b0, flush = 1'b0;
    logic [W-1:0] readData, ALUResult_wb;
    logic [2:0]   controlsignals_wb;
    logic [4:0]   Rd_wb;
    logic         misalign;

    fourth_stage #(.Width(W), .Depth(D)) dut (
        .clk(clk), .rst(rst), .ALUResult(ALUResult), .WriteData(WriteData),
        .Rd(Rd), .funct3(funct3), .controlsignals(controlsignals),
        .stall(stall), .flush(flush), .readData(readData),
        .ALUResult_wb(ALUResult_wb), .controlsignals_wb(controlsignals_wb),
        .Rd_wb(Rd_wb), .misalign(misalign)
    );

    always #5 clk = ~clk;

    byte unsigned mem_m [4*D];
    logic [31:0] e_rd, e_alu;
    logic [2:0]  e_cs;
    logic [4:0]  e_rdst;
    logic        e_mis;
    int n_cmp = 0;
    int n_bad = 0;

    // Apply one transaction, clock it, and advance the reference model.
    task automatic step(input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] rdst, input logic [2:0] f3,
                        input logic [4:0] cs, input logic st, input logic fl);
        int nb, base;
        bit sg, mis;
        longint val;
        logic [31:0] ld;
        ALUResult = a; WriteData = wd; Rd = rdst; funct3 = f3;
        controlsignals = cs; stall = st; flush = fl;
        case (f3)
            3'b000: begin nb = 1; sg = 1; end
            3'b001: begin nb = 2; sg = 1; end
            3'b010: begin nb = 4; sg = 0; end
            3'b100: begin nb = 1; sg = 0; end
            3'b101: begin nb = 2; sg = 0; end
            default: begin nb = 0; sg = 0; end
        endcase
        mis = cs[4] && (cs[1] || cs[0]) &&
              (nb == 0 || (int'(a[1:0]) % nb) != 0);
        base = int'(a % (4*D));
        val = 0;
        if (!mis && nb > 0)
            for (int k = 0; k < nb; k++)
                val = val | (longint'(mem_m[base+k]) << (8*k));
        if (sg && nb > 0 && val[8*nb-1])
            val = val - (longint'(1) << (8*nb));
        ld = (cs[4] && cs[1] && !cs[0] && !mis) ? val[31:0] : 32'd0;
        @(posedge clk);
        if (cs[4] && cs[0] && !mis && !st)
            for (int k = 0; k < nb; k++)
                mem_m[base+k] = 8'(wd >> (8*k));
        if (fl) begin
            e_rd = 0; e_alu = 0; e_cs = 0; e_rdst = 0; e_mis = 0;
        end else if (!st) begin
            e_rd = ld; e_alu = a; e_rdst = rdst; e_mis = mis;
            e_cs = {cs[4], cs[4] & cs[3] & !mis, cs[2]};
        end
        #1;
    endtask

    task automatic test_reset_state();
        #1;
        n_cmp++;
        if ({readData, ALUResult_wb, controlsignals_wb, Rd_wb, misalign} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got %h/%h/%b/%0d/%b want all 0",
                     readData, ALUResult_wb, controlsignals_wb, Rd_wb, misalign);
        end
        @(negedge clk);
        rst = 1'b1;
        e_rd = 0; e_alu = 0; e_cs = 0; e_rdst = 0; e_mis = 0;
    endtask

    task automatic test_init();
        for (int j = 0; j < D; j++)
            step(32'(4*j), $urandom, 5'd0, 3'b010, ST, 1'b0, 1'b0);
    endtask

    task automatic test_sw_lw();
        step(32'h10, 32'hDEADBEEF, 5'd0, 3'b010, ST, 1'b0, 1'b0);
        step(32'h10, 32'h0, 5'd5, 3'b010, LD, 1'b0, 1'b0);
        n_cmp++;
        if (readData !== 32'hDEADBEEF || controlsignals_wb !== 3'b111 ||
            Rd_wb !== 5'd5 || misalign !== 1'b0) begin
            n_bad++;
            $display("FAIL sw_lw: got %h cs=%b rd=%0d mis=%b want deadbeef cs=111 rd=5 mis=0",
                     readData, controlsignals_wb, Rd_wb, misalign);
        end
    endtask

    task automatic test_byte();
        step(32'h11, 32'h80, 5'd0, 3'b000, ST, 1'b0, 1'b0);
        step(32'h11, 32'h0, 5'd6, 3'b000, LD, 1'b0, 1'b0);
        n_cmp++;
        if (readData !== 32'hFFFFFF80) begin
            n_bad++; $display("FAIL lb: got %h want ffffff80", readData);
        end
        step(32'h11, 32'h0, 5'd6, 3'b100, LD, 1'b0, 1'b0);
        n_cmp++;
        if (readData !== 32'h00000080) begin
            n_bad++; $display("FAIL lbu: got %h want 00000080", readData);
        end
        step(32'h10, 32'h0, 5'd6, 3'b010, LD, 1'b0, 1'b0);
        n_cmp++;
        if (readData !== 32'hDEAD80EF) begin
            n_bad++; $display("FAIL lw_merged: got %h want dead80ef", readData);
        end
    endtask

    task automatic test_half_misalign();
        logic [31:0] w14;
        step(32'h12, 32'h0, 5'd7, 3'b001, LD, 1'b0, 1'b0);
        n_cmp++;
        if (readData !== 32'hFFFFDEAD) begin
            n_bad++; $display("FAIL lh: got %h want ffffdead", readData);
        end
        step(32'h12, 32'h0, 5'd7, 3'b101, LD, 1'b0, 1'b0);
        n_cmp++;
        if (readData !== 32'h0000DEAD) begin
            n_bad++; $display("FAIL lhu: got %h want 0000dead", readData);
        end
        step(32'h13, 32'h0, 5'd7, 3'b001, LD, 1'b0, 1'b0);
        n_cmp++;
        if (misalign !== 1'b1 || readData !== 32'h0 || controlsignals_wb[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL lh_misalign: got mis=%b data=%h cs=%b want mis=1 data=0 regwrite=0",
                     misalign, readData, controlsignals_wb);
        end
        w14 = {mem_m[8'h17], mem_m[8'h16], mem_m[8'h15], mem_m[8'h14]};
        step(32'h16, 32'h12345678, 5'd0, 3'b010, ST, 1'b0, 1'b0);
        n_cmp++;
        if (misalign !== 1'b1) begin
            n_bad++; $display("FAIL sw_misalign_flag: got %b want 1", misalign);
        end
        step(32'h14, 32'h0, 5'd8, 3'b010, LD, 1'b0, 1'b0);
        n_cmp++;
        if (readData !== w14 || misalign !== 1'b0) begin
            n_bad++;
            $display("FAIL sw_misalign_mem: got %h mis=%b want %h mis=0", readData, misalign, w14);
        end
        step(32'h20, 32'h0, 5'd8, 3'b011, LD, 1'b0, 1'b0);
        n_cmp++;
        if (misalign !== 1'b1 || readData !== 32'h0 || controlsignals_wb !== 3'b101) begin
            n_bad++;
            $display("FAIL unsupported_f3: got mis=%b data=%h cs=%b want mis=1 data=0 cs=101",
                     misalign, readData, controlsignals_wb);
        end
    endtask

    task automatic test_wrap();
        step(32'h100, 32'hCAFEF00D, 5'd0, 3'b010, ST, 1'b0, 1'b0);
        step(32'h000, 32'h0, 5'd9, 3'b010, LD, 1'b0, 1'b0);
        n_cmp++;
        if (readData !== 32'hCAFEF00D) begin
            n_bad++; $display("FAIL wrap: got %h want cafef00d", readData);
        end
    endtask

    task automatic test_stall_flush();
        logic [31:0] w20;
        w20 = {mem_m[8'h23], mem_m[8'h22], mem_m[8'h21], mem_m[8'h20]};
        step(32'h13, 32'h0, 5'd4, 3'b001, LD, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            step(32'h20, 32'h11112222, 5'd7, 3'b010, ST, 1'b1, 1'b0);
            n_cmp++;
            if (ALUResult_wb !== 32'h13 || Rd_wb !== 5'd4 || misalign !== 1'b1 ||
                controlsignals_wb !== 3'b101) begin
                n_bad++;
                $display("FAIL stall_hold: got alu=%h rd=%0d mis=%b cs=%b want 13/4/1/101",
                         ALUResult_wb, Rd_wb, misalign, controlsignals_wb);
            end
        end
        step(32'h20, 32'h11112222, 5'd7, 3'b010, ST, 1'b1, 1'b1);
        n_cmp++;
        if ({readData, ALUResult_wb, controlsignals_wb, Rd_wb, misalign} !== '0) begin
            n_bad++;
            $display("FAIL flush_stall: got %h/%h/%b/%0d/%b want all 0",
                     readData, ALUResult_wb, controlsignals_wb, Rd_wb, misalign);
        end
        step(32'h20, 32'h0, 5'd3, 3'b010, LD, 1'b0, 1'b0);
        n_cmp++;
        if (readData !== w20) begin
            n_bad++; $display("FAIL stall_nostore: got %h want %h", readData, w20);
        end
        step(32'h24, 32'hA5A55A5A, 5'd0, 3'b010, ST, 1'b0, 1'b1);
        step(32'h24, 32'h0, 5'd3, 3'b010, LD, 1'b0, 1'b0);
        n_cmp++;
        if (readData !== 32'hA5A55A5A) begin
            n_bad++; $display("FAIL flush_store: got %h want a5a55a5a", readData);
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] w28;
        w28 = {mem_m[8'h2B], mem_m[8'h2A], mem_m[8'h29], mem_m[8'h28]};
        step(32'h10, 32'h0, 5'd5, 3'b010, LD, 1'b0, 1'b0);
        ALUResult = 32'h28; WriteData = 32'h55667788; funct3 = 3'b010;
        controlsignals = ST; Rd = 5'd0;
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({readData, ALUResult_wb, controlsignals_wb, Rd_wb, misalign} !== '0) begin
            n_bad++;
            $display("FAIL reset_async: got %h/%h/%b/%0d/%b want all 0",
                     readData, ALUResult_wb, controlsignals_wb, Rd_wb, misalign);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        e_rd = 0; e_alu = 0; e_cs = 0; e_rdst = 0; e_mis = 0;
        step(32'h28, 32'h0, 5'd2, 3'b010, LD, 1'b0, 1'b0);
        n_cmp++;
        if (readData !== w28) begin
            n_bad++; $display("FAIL reset_store_lost: got %h want %h", readData, w28);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [4:0]  cs;
        for (int i = 0; i < 400; i++) begin
            a = {$urandom_range(0, 3) == 0 ? 24'($urandom) : 24'h0, 8'($urandom)};
            cs = 5'($urandom);
            if ($urandom_range(0, 3) != 0) cs[4] = 1'b1;
            step(a, $urandom, 5'($urandom), 3'($urandom), cs,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
            n_cmp++;
            if ({readData, ALUResult_wb, controlsignals_wb, Rd_wb, misalign} !==
                {e_rd, e_alu, e_cs, e_rdst, e_mis}) begin
                n_bad++;
                $display("FAIL random[%0d]: got %h/%h/%b/%0d/%b want %h/%h/%b/%0d/%b", i,
                         readData, ALUResult_wb, controlsignals_wb, Rd_wb, misalign,
                         e_rd, e_alu, e_cs, e_rdst, e_mis);
            end
        end
    endtask

    initial begin
        test_reset_state();
        test_init();
        test_sw_lw();
        test_byte();
        test_half_misalign();
        test_wrap();
        test_stall_flush();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
